// File: rtl/matmul_pkg.sv
// Shared definitions for the time-multiplexed matrix multiplier.
//   DATA_W  : operand element width (unsigned)
//   RES_W   : result / accumulator width (unsigned, wraps mod 2^RES_W)
//   state_t : sequencer FSM states
//   cnt_w() : counter width for a count of n items, never below 1 bit
package matmul_pkg;

    localparam int DATA_W = 20;
    localparam int RES_W  = 40;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        MAC,
        EMIT
    } state_t;

    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/matmul_mac.sv
// Single multiply-accumulate stage.
//   clk, reset : clock, synchronous active-high reset (clears acc)
//   en         : update the accumulator this cycle
//   clr        : first term of a dot product; restart from zero instead of acc
//   a, b       : unsigned operands
//   acc        : registered running sum, wraps modulo 2^RES_W
module matmul_mac
    import matmul_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              clr,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [RES_W-1:0]  acc
);

    logic [RES_W-1:0] prod;

    assign prod = RES_W'(a) * RES_W'(b);

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (en) begin
            acc <= (clr ? '0 : acc) + prod;
        end
    end

endmodule

// File: rtl/matmul_sequencer.sv
// Computes C = A x B with one MAC per cycle.
// Operands arrive on one stream: all of A row-major, then all of B row-major.
// Results leave row-major on the output stream.
// Both streams use valid/ready: a transfer happens on a rising edge where
// valid && ready. Once out_valid is raised, out_data and out_last hold until
// that transfer happens.
//   clk, reset         : clock, synchronous active-high reset (aborts any job)
//   start              : begin a job; looked at only in IDLE
//   in_valid, in_data  : operand element stream
//   in_ready           : high in LOAD_A / LOAD_B only
//   out_valid/out_data : result element stream
//   out_last           : marks C[aRow-1][bCol-1]
//   out_ready          : consumer accepts the result
//   busy               : high in every state except IDLE
//   done               : one-cycle pulse after the final result transfer
//   dbg_state          : current FSM state, for observation only
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int aRow = 2,
    parameter int aCol = 2,
    parameter int bCol = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [RES_W-1:0]  out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output state_t            dbg_state
);

    localparam int A_N = aRow * aCol;
    localparam int B_N = aCol * bCol;
    localparam int IW  = cnt_w(aRow);
    localparam int KW  = cnt_w(aCol);
    localparam int JW  = cnt_w(bCol);
    localparam int AW  = cnt_w(A_N);
    localparam int BW  = cnt_w(B_N);
    localparam int LW  = (AW > BW) ? AW : BW;

    localparam logic [LW-1:0] A_LAST = LW'(A_N - 1);
    localparam logic [LW-1:0] B_LAST = LW'(B_N - 1);
    localparam logic [IW-1:0] I_LAST = IW'(aRow - 1);
    localparam logic [KW-1:0] K_LAST = KW'(aCol - 1);
    localparam logic [JW-1:0] J_LAST = JW'(bCol - 1);

    state_t            state;
    logic [LW-1:0]     ld_idx;
    logic [IW-1:0]     i_cnt;
    logic [JW-1:0]     j_cnt;
    logic [KW-1:0]     k_cnt;
    logic [DATA_W-1:0] a_buf [A_N];
    logic [DATA_W-1:0] b_buf [B_N];
    logic [AW-1:0]     a_idx;
    logic [BW-1:0]     b_idx;
    logic              mac_en;
    logic              mac_clr;
    logic [RES_W-1:0]  acc;

    // Row-major element addresses of A[i][k] and B[k][j]
    assign a_idx   = AW'(int'(i_cnt) * aCol + int'(k_cnt));
    assign b_idx   = BW'(int'(k_cnt) * bCol + int'(j_cnt));
    assign mac_en  = (state == MAC);
    assign mac_clr = (k_cnt == '0);

    matmul_mac u_mac (
        .clk   (clk),
        .reset (reset),
        .en    (mac_en),
        .clr   (mac_clr),
        .a     (a_buf[a_idx]),
        .b     (b_buf[b_idx]),
        .acc   (acc)
    );

    // acc only changes in MAC, so it is stable for the whole of EMIT
    assign out_data  = acc;
    assign in_ready  = (state == LOAD_A) || (state == LOAD_B);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ld_idx    <= '0;
            i_cnt     <= '0;
            j_cnt     <= '0;
            k_cnt     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= LOAD_A;
                        ld_idx <= '0;
                    end
                end
                LOAD_A: begin
                    if (in_valid) begin
                        a_buf[AW'(ld_idx)] <= in_data;
                        if (ld_idx == A_LAST) begin
                            ld_idx <= '0;
                            state  <= LOAD_B;
                        end else begin
                            ld_idx <= ld_idx + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (in_valid) begin
                        b_buf[BW'(ld_idx)] <= in_data;
                        if (ld_idx == B_LAST) begin
                            ld_idx <= '0;
                            i_cnt  <= '0;
                            j_cnt  <= '0;
                            k_cnt  <= '0;
                            state  <= MAC;
                        end else begin
                            ld_idx <= ld_idx + 1'b1;
                        end
                    end
                end
                MAC: begin
                    if (k_cnt == K_LAST) begin
                        k_cnt     <= '0;
                        out_valid <= 1'b1;
                        out_last  <= (i_cnt == I_LAST) && (j_cnt == J_LAST);
                        state     <= EMIT;
                    end else begin
                        k_cnt <= k_cnt + 1'b1;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (out_last) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            if (j_cnt == J_LAST) begin
                                j_cnt <= '0;
                                i_cnt <= i_cnt + 1'b1;
                            end else begin
                                j_cnt <= j_cnt + 1'b1;
                            end
                            state <= MAC;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: three instances (2x2x2, 1x1x1, 1x2x1) sharing
// clock and reset; one instance is driven at a time, selected by cur.
module tb_matmul_sequencer;
    import matmul_pkg::*;

    localparam int W = RES_W + 1;  // {last, data}

    logic              clk;
    logic              reset;
    logic              start_s     [3];
    logic              in_valid_s  [3];
    logic [DATA_W-1:0] in_data_s   [3];
    logic              in_ready_s  [3];
    logic              out_valid_s [3];
    logic [RES_W-1:0]  out_data_s  [3];
    logic              out_last_s  [3];
    logic              out_ready_s [3];
    logic              busy_s      [3];
    logic              done_s      [3];
    state_t            st_s        [3];

    logic [W-1:0]      exp_q[$];
    int                n_tests = 0;
    int                n_fail  = 0;
    int                cur     = 0;
    int                rdy_mode = 0;   // 0: always ready, 1: random, 2: held low
    int                done_cnt = 0;
    logic              pend_done = 1'b0;
    logic              held = 1'b0;
    logic [RES_W-1:0]  hold_data;
    logic              hold_last;
    logic              rdy;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    matmul_sequencer #(.aRow(2), .aCol(2), .bCol(2)) u0 (
        .clk(clk), .reset(reset), .start(start_s[0]), .in_valid(in_valid_s[0]),
        .in_data(in_data_s[0]), .in_ready(in_ready_s[0]), .out_valid(out_valid_s[0]),
        .out_data(out_data_s[0]), .out_last(out_last_s[0]), .out_ready(out_ready_s[0]),
        .busy(busy_s[0]), .done(done_s[0]), .dbg_state(st_s[0]));

    matmul_sequencer #(.aRow(1), .aCol(1), .bCol(1)) u1 (
        .clk(clk), .reset(reset), .start(start_s[1]), .in_valid(in_valid_s[1]),
        .in_data(in_data_s[1]), .in_ready(in_ready_s[1]), .out_valid(out_valid_s[1]),
        .out_data(out_data_s[1]), .out_last(out_last_s[1]), .out_ready(out_ready_s[1]),
        .busy(busy_s[1]), .done(done_s[1]), .dbg_state(st_s[1]));

    matmul_sequencer #(.aRow(1), .aCol(2), .bCol(1)) u2 (
        .clk(clk), .reset(reset), .start(start_s[2]), .in_valid(in_valid_s[2]),
        .in_data(in_data_s[2]), .in_ready(in_ready_s[2]), .out_valid(out_valid_s[2]),
        .out_data(out_data_s[2]), .out_last(out_last_s[2]), .out_ready(out_ready_s[2]),
        .busy(busy_s[2]), .done(done_s[2]), .dbg_state(st_s[2]));

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- output monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (reset) begin
            pend_done = 1'b0;
            held      = 1'b0;
        end else begin
            chk("done", W'(done_s[cur]), W'(pend_done));
            if (pend_done) chk("busy_at_done", W'(busy_s[cur]), W'(0));
            if (done_s[cur]) done_cnt++;
            pend_done = 1'b0;
            if (out_valid_s[cur]) begin
                if (held) begin
                    chk("stall_data", W'(out_data_s[cur]), W'(hold_data));
                    chk("stall_last", W'(out_last_s[cur]), W'(hold_last));
                end
                case (rdy_mode)
                    0:       rdy = 1'b1;
                    1:       rdy = 1'($urandom_range(0, 1));
                    default: rdy = 1'b0;
                endcase
                out_ready_s[cur] = rdy;
                if (rdy) begin
                    held = 1'b0;
                    if (exp_q.size() == 0) begin
                        chk("exp_q_nonempty", W'(exp_q.size()), W'(1));
                    end else begin
                        logic [W-1:0] e;
                        e = exp_q.pop_front();
                        chk("out_data", W'(out_data_s[cur]), W'(e[RES_W-1:0]));
                        chk("out_last", W'(out_last_s[cur]), W'(e[RES_W]));
                        pend_done = e[RES_W];
                    end
                end else begin
                    held      = 1'b1;
                    hold_data = out_data_s[cur];
                    hold_last = out_last_s[cur];
                end
            end else begin
                held = 1'b0;
                out_ready_s[cur] = 1'($urandom_range(0, 1));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load_elem(input int d, input logic [DATA_W-1:0] v);
        int n;
        @(negedge clk);
        in_valid_s[d] = 1'b1;
        in_data_s[d]  = v;
        n = 0;
        while (!in_ready_s[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready_s[d]) begin
            chk("in_ready_timeout", W'(in_ready_s[d]), W'(1));
        end else begin
            @(posedge clk);
        end
        #1 in_valid_s[d] = 1'b0;
    endtask

    task automatic pulse_start(input int d);
        @(negedge clk);
        start_s[d] = 1'b1;
        @(negedge clk);
        start_s[d] = 1'b0;
        chk("in_ready_after_start", W'(in_ready_s[d]), W'(1));
        chk("busy_after_start", W'(busy_s[d]), W'(1));
    endtask

    task automatic run_job(input int d, input int ar, input int ac, input int bc,
                           input logic [DATA_W-1:0] a[4], input logic [DATA_W-1:0] b[4],
                           input int mode, input bit poke_b, input bit poke_e);
        logic [63:0] s;
        int          base;
        int          n;
        // reference model
        for (int i = 0; i < ar; i++) begin
            for (int j = 0; j < bc; j++) begin
                s = '0;
                for (int k = 0; k < ac; k++)
                    s = s + 64'(a[i*ac+k]) * 64'(b[k*bc+j]);
                exp_q.push_back({1'((i == ar-1) && (j == bc-1)), s[RES_W-1:0]});
            end
        end
        rdy_mode = poke_e ? 2 : mode;
        base = done_cnt;
        pulse_start(d);
        for (int n2 = 0; n2 < ar*ac; n2++) load_elem(d, a[n2]);
        if (poke_b) begin
            @(negedge clk);
            start_s[d] = 1'b1;
            @(negedge clk);
            start_s[d] = 1'b0;
            chk("start_ignored_load_b", W'(st_s[d]), W'(LOAD_B));
        end
        for (int n2 = 0; n2 < ac*bc; n2++) load_elem(d, b[n2]);
        for (int m = 0; m < ac; m++) begin
            @(negedge clk);
            chk("ov_during_mac", W'(out_valid_s[d]), W'(0));
        end
        @(negedge clk);
        chk("ov_after_mac", W'(out_valid_s[d]), W'(1));
        if (poke_e) begin
            start_s[d] = 1'b1;
            @(negedge clk);
            start_s[d] = 1'b0;
            chk("start_ignored_emit", W'(st_s[d]), W'(EMIT));
            chk("ov_held_emit", W'(out_valid_s[d]), W'(1));
            rdy_mode = mode;
        end
        n = 0;
        while (done_cnt == base && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("job_done_count", W'(done_cnt - base), W'(1));
        chk("exp_q_drained", W'(exp_q.size()), W'(0));
        exp_q.delete();
        rdy_mode = 0;
    endtask

    // ---------------- main sequence ----------------
    logic [DATA_W-1:0] a22 [4];
    logic [DATA_W-1:0] b22 [4];

    initial begin
        a22 = '{20'd1, 20'd2, 20'd3, 20'd4};
        b22 = '{20'd5, 20'd6, 20'd7, 20'd8};
        for (int d = 0; d < 3; d++) begin
            start_s[d] = 1'b0; in_valid_s[d] = 1'b0;
            in_data_s[d] = '0; out_ready_s[d] = 1'b0;
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_state", W'(st_s[d]), W'(IDLE));
            chk("rst_in_ready", W'(in_ready_s[d]), W'(0));
            chk("rst_out_valid", W'(out_valid_s[d]), W'(0));
            chk("rst_out_data", W'(out_data_s[d]), W'(0));
            chk("rst_out_last", W'(out_last_s[d]), W'(0));
            chk("rst_busy", W'(busy_s[d]), W'(0));
            chk("rst_done", W'(done_s[d]), W'(0));
        end
        reset = 1'b0;

        // in_valid while idle is ignored
        cur = 0;
        @(negedge clk);
        in_valid_s[0] = 1'b1;
        in_data_s[0]  = 20'd999;
        repeat (3) begin
            @(negedge clk);
            chk("idle_in_ready", W'(in_ready_s[0]), W'(0));
            chk("idle_state", W'(st_s[0]), W'(IDLE));
        end
        in_valid_s[0] = 1'b0;

        // 2x2x2 jobs: plain, random backpressure + start in LOAD_B, start in EMIT
        run_job(0, 2, 2, 2, a22, b22, 0, 1'b0, 1'b0);
        run_job(0, 2, 2, 2, a22, b22, 1, 1'b1, 1'b0);
        run_job(0, 2, 2, 2, a22, b22, 1, 1'b0, 1'b1);
        run_job(0, 2, 2, 2, '{20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom)},
                '{20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom)}, 1, 1'b0, 1'b0);

        // 1x1x1: 3 * 4
        @(negedge clk);
        cur = 1;
        run_job(1, 1, 1, 1, '{20'd3, 20'd0, 20'd0, 20'd0}, '{20'd4, 20'd0, 20'd0, 20'd0},
                0, 1'b0, 1'b0);

        // 1x2x1 with all-ones operands: accumulation wraps
        @(negedge clk);
        cur = 2;
        run_job(2, 1, 2, 1, '{20'hFFFFF, 20'hFFFFF, 20'd0, 20'd0},
                '{20'hFFFFF, 20'hFFFFF, 20'd0, 20'd0}, 0, 1'b0, 1'b0);

        // reset in the middle of MAC aborts without done
        @(negedge clk);
        cur = 0;
        pulse_start(0);
        for (int n2 = 0; n2 < 4; n2++) load_elem(0, a22[n2]);
        for (int n2 = 0; n2 < 4; n2++) load_elem(0, b22[n2]);
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_state", W'(st_s[0]), W'(MAC));
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_state", W'(st_s[0]), W'(IDLE));
        chk("mid_rst_out_valid", W'(out_valid_s[0]), W'(0));
        chk("mid_rst_out_data", W'(out_data_s[0]), W'(0));
        chk("mid_rst_out_last", W'(out_last_s[0]), W'(0));
        chk("mid_rst_busy", W'(busy_s[0]), W'(0));
        chk("mid_rst_done", W'(done_s[0]), W'(0));
        chk("mid_rst_in_ready", W'(in_ready_s[0]), W'(0));
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("no_done_after_abort", W'(st_s[0]), W'(IDLE));
        run_job(0, 2, 2, 2, a22, b22, 0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
